cell_rasterizer: RTL and testbench

Expands one 128x128 world-map cell address into the stream of 1024x768 screen pixel coordinates that the cell covers. This is the inverse of the screen-to-world scaling, where column is divided by 8 and row by 6. Sits between world-map update logic (e.g. a changed-cell queue) and any pixel-level consumer such as an overlay writer or a frame-buffer painter. Uses valid/ready handshakes on both sides; each accepted cell produces exactly 48 output beats.

---
 rtl/cell_rasterizer_pkg.sv | 17 +
 rtl/cell_rasterizer.sv | 115 +++++++++++
 tb/tb_cell_rasterizer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/cell_rasterizer_pkg.sv
// Screen/map geometry shared by the world<->screen scaling blocks,
// plus the rasterizer state encoding.
package cell_rasterizer_pkg;

    localparam int unsigned SCREEN_W       = 1024;
    localparam int unsigned SCREEN_H       = 768;
    localparam int unsigned MAP_W          = 7;
    localparam int unsigned H_SHIFT        = 3;
    localparam int unsigned V_SCALE        = 6;
    localparam int unsigned BEATS_PER_CELL = 48;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/cell_rasterizer.sv
// Expands one world-map cell address into the row-major stream of screen
// pixel coordinates it covers (8 columns x 6 rows per cell).
module cell_rasterizer
    import cell_rasterizer_pkg::*;
#(
    parameter int unsigned MAP_W   = 7,
    parameter int unsigned PIX_W   = 12,
    parameter int unsigned H_SHIFT = 3,
    parameter int unsigned V_SCALE = 6
)(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*MAP_W-1:0]   in_addr,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PIX_W-1:0]     out_column,
    output logic [PIX_W-1:0]     out_row,
    output logic                 out_last
);

    localparam int unsigned DY_W = $clog2(V_SCALE);
    localparam logic [H_SHIFT-1:0] DX_MAX = '1;
    localparam logic [DY_W-1:0]    DY_MAX = DY_W'(V_SCALE - 1);

    state_t               r_state;
    logic [PIX_W-1:0]     r_base_col;
    logic [PIX_W-1:0]     r_base_row;
    logic [H_SHIFT-1:0]   r_dx;
    logic [DY_W-1:0]      r_dy;
    logic [PIX_W-1:0]     r_out_column;
    logic [PIX_W-1:0]     r_out_row;
    logic                 r_out_last;
    logic                 r_out_valid;

    logic [MAP_W-1:0]     w_col;
    logic [MAP_W-1:0]     w_row;
    logic [PIX_W-1:0]     w_row_ext;
    logic [PIX_W-1:0]     w_base_col;
    logic [PIX_W-1:0]     w_base_row;
    logic                 w_dx_wrap;
    logic [H_SHIFT-1:0]   w_next_dx;
    logic [DY_W-1:0]      w_next_dy;

    assign w_col      = in_addr[MAP_W-1:0];
    assign w_row      = in_addr[2*MAP_W-1:MAP_W];
    assign w_row_ext  = PIX_W'(w_row);
    assign w_base_col = PIX_W'(w_col) << H_SHIFT;
    // row*6 as a shift-add pair; no multiplier or divider in the path
    assign w_base_row = (w_row_ext << 2) + (w_row_ext << 1);

    assign w_dx_wrap  = (r_dx == DX_MAX);
    assign w_next_dx  = r_dx + 1'b1;
    assign w_next_dy  = w_dx_wrap ? r_dy + 1'b1 : r_dy;

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = r_out_valid;
    assign out_column = r_out_column;
    assign out_row    = r_out_row;
    assign out_last   = r_out_last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_base_col   <= '0;
            r_base_row   <= '0;
            r_dx         <= '0;
            r_dy         <= '0;
            r_out_column <= '0;
            r_out_row    <= '0;
            r_out_last   <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && !abort) begin
                        r_base_col   <= w_base_col;
                        r_base_row   <= w_base_row;
                        r_dx         <= '0;
                        r_dy         <= '0;
                        r_out_column <= w_base_col;
                        r_out_row    <= w_base_row;
                        r_out_last   <= 1'b0;
                        r_out_valid  <= 1'b1;
                        r_state      <= EMIT;
                    end
                end
                EMIT: begin
                    if (abort) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_state     <= IDLE;
                    end else if (out_ready) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_state     <= IDLE;
                        end else begin
                            // outputs are registered, so they are built from the next dx/dy
                            r_dx         <= w_next_dx;
                            r_dy         <= w_next_dy;
                            r_out_column <= r_base_col + PIX_W'(w_next_dx);
                            r_out_row    <= r_base_row + PIX_W'(w_next_dy);
                            r_out_last   <= (w_next_dx == DX_MAX) && (w_next_dy == DY_MAX);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_rasterizer.sv
// Directed + randomized bench for cell_rasterizer against an arithmetic
// model of the cell-to-pixel mapping.
module tb_cell_rasterizer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] in_addr;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_column;
    logic [11:0] out_row;
    logic        out_last;

    int checks = 0;
    int errors = 0;

    cell_rasterizer #(
        .MAP_W   (7),
        .PIX_W   (12),
        .H_SHIFT (3),
        .V_SCALE (6)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_column (out_column),
        .out_row    (out_row),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference mapping: beat b of cell (row,col) is pixel (col*8 + b%8, row*6 + b/8).
    function automatic int exp_col(input logic [13:0] a, input int b);
        return int'(a[6:0]) * 8 + (b % 8);
    endfunction

    function automatic int exp_row(input logic [13:0] a, input int b);
        return int'(a[13:7]) * 6 + (b / 8);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),   1);
        check({tag, "_out_valid"}, 32'(out_valid),  0);
        check({tag, "_out_last"},  32'(out_last),   0);
        check({tag, "_out_col"},   32'(out_column), 0);
        check({tag, "_out_row"},   32'(out_row),    0);
    endtask

    // Sends one cell and follows its beats. A non-negative stall_at holds
    // out_ready low for 3 cycles at that beat; abort_at / reset_at cut the cell.
    task automatic run_cell(input logic [13:0] addr, input bit rand_bp,
                            input int stall_at, input int abort_at, input int reset_at);
        int beat = 0;
        int cyc = 0;
        int stalls = 0;
        @(negedge clk);
        check("accept_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_addr  = addr;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_addr  = 14'($urandom);
        while (beat < 48 && cyc < 2000) begin
            cyc++;
            check("emit_valid",    32'(out_valid),  1);
            check("emit_in_ready", 32'(in_ready),   0);
            check("beat_col",      32'(out_column), 32'(exp_col(addr, beat)));
            check("beat_row",      32'(out_row),    32'(exp_row(addr, beat)));
            check("beat_last",     32'(out_last),   32'(beat == 47));
            check("rt_col",        32'(out_column >> 3), 32'(addr[6:0]));
            check("rt_row",        32'(out_row / 6),     32'(addr[13:7]));
            if (beat == abort_at) begin
                abort = 1'b1;
                out_ready = 1'($urandom);
                @(posedge clk);
                #1;
                abort = 1'b0;
                check("abort_valid",    32'(out_valid), 0);
                check("abort_last",     32'(out_last),  0);
                check("abort_in_ready", 32'(in_ready),  1);
                return;
            end
            if (beat == reset_at) begin
                resetn = 1'b0;
                #1;
                check_reset_outputs("midcell_reset");
                @(negedge clk);
                resetn = 1'b1;
                out_ready = 1'b1;
                return;
            end
            if (beat == stall_at && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else if (rand_bp) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            @(posedge clk);
            if (out_ready) beat++;
            @(negedge clk);
        end
        check("beat_count", 32'(beat), 48);
        check("done_valid",    32'(out_valid), 0);
        check("done_in_ready", 32'(in_ready),  1);
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_addr   = '0;
        abort     = 1'b0;
        out_ready = 1'b1;
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        run_cell(14'h0000, 1'b0, -1, -1, -1);
        run_cell(14'h3FFF, 1'b0, -1, -1, -1);
        run_cell(14'h0082, 1'b0, -1, -1, -1);
        run_cell(14'h1234, 1'b0,  9, -1, -1);

        run_cell(14'h2A55, 1'b0, -1, 20, -1);
        run_cell(14'h0101, 1'b0, -1, -1, -1);

        @(negedge clk);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_addr  = 14'($urandom);
        @(posedge clk);
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        check("idle_abort_valid",    32'(out_valid), 0);
        check("idle_abort_in_ready", 32'(in_ready),  1);

        run_cell(14'h3A07, 1'b0, -1, -1, 30);
        run_cell(14'h05C3, 1'b0, -1, -1, -1);

        for (int n = 0; n < 12; n++) begin
            run_cell(14'($urandom), 1'b1, -1, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
